// File: rtl/irq_controller_if.sv
// CPU-side register port of the interrupt controller (IE/IF/IME window at 0x200).
// Strobes are single-cycle with no backpressure: bus_we/bus_re each mark one access;
// bus_rvalid pulses exactly one cycle after bus_re and qualifies bus_rdata.
interface irq_controller_if;
    logic [3:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic [1:0]  bus_be;
    logic        bus_re;
    logic [15:0] bus_rdata;
    logic        bus_rvalid;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_be, bus_re,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_be, bus_re,
        output bus_rdata, bus_rvalid
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller: rising-edge capture into IF, masking by IE/IME,
// registered CPU IRQ and halt-wake pending line, 16-bit register port.
module irq_controller #(
    parameter int NUM_SRC = 14
) (
    input  logic               clock_16,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    irq_controller_if.slave    bus,
    output logic               cpu_irq,
    output logic               irq_pending
);

    localparam logic [3:0] ADDR_IE  = 4'h0;
    localparam logic [3:0] ADDR_IF  = 4'h2;
    localparam logic [3:0] ADDR_IME = 4'h8;

    logic [NUM_SRC-1:0] ie_q, if_q, src_prev;
    logic [NUM_SRC-1:0] src_event, wr_bits, be_bits, clr, ie_next, if_next;
    logic               ime_q, ime_next;
    logic [15:0]        byte_mask, wdata_masked, rd_mux;
    logic               unused_wdata;

    always_comb begin
        byte_mask    = {{8{bus.bus_be[1]}}, {8{bus.bus_be[0]}}};
        wdata_masked = bus.bus_wdata & byte_mask;
        wr_bits      = wdata_masked[NUM_SRC-1:0];
        be_bits      = byte_mask[NUM_SRC-1:0];
        unused_wdata = ^{wdata_masked, byte_mask};

        src_event = irq_src & ~src_prev;

        // A new event on a bit being cleared this cycle keeps the bit set.
        clr     = (bus.bus_we && bus.bus_addr == ADDR_IF) ? wr_bits : '0;
        if_next = (if_q & ~clr) | src_event;

        ie_next = ie_q;
        if (bus.bus_we && bus.bus_addr == ADDR_IE)
            ie_next = (ie_q & ~be_bits) | wr_bits;

        ime_next = ime_q;
        if (bus.bus_we && bus.bus_addr == ADDR_IME && bus.bus_be[0])
            ime_next = bus.bus_wdata[0];

        rd_mux = '0;
        case (bus.bus_addr)
            ADDR_IE:  rd_mux[NUM_SRC-1:0] = ie_q;
            ADDR_IF:  rd_mux[NUM_SRC-1:0] = if_q;
            ADDR_IME: rd_mux[0]           = ime_q;
            default:  rd_mux              = '0;
        endcase
    end

    always_ff @(posedge clock_16) begin
        if (reset) begin
            // Loading the live request lines stops a level already high at release from firing.
            src_prev       <= irq_src;
            ie_q           <= '0;
            if_q           <= '0;
            ime_q          <= 1'b0;
            bus.bus_rdata  <= '0;
            bus.bus_rvalid <= 1'b0;
            cpu_irq        <= 1'b0;
            irq_pending    <= 1'b0;
        end else begin
            src_prev       <= irq_src;
            ie_q           <= ie_next;
            if_q           <= if_next;
            ime_q          <= ime_next;
            bus.bus_rvalid <= bus.bus_re;
            if (bus.bus_re)
                bus.bus_rdata <= rd_mux;
            irq_pending    <= |(ie_q & if_q);
            cpu_irq        <= ime_q & (|(ie_q & if_q));
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed test-plan scenarios with literal expectations,
// then randomized traffic checked every cycle against a bit-level behavioural model.
module tb_irq_controller;
    localparam int N = 14;

    logic         clock_16 = 1'b0;
    logic         reset;
    logic [N-1:0] irq_src;
    logic         cpu_irq;
    logic         irq_pending;

    irq_controller_if bus_if ();

    irq_controller #(.NUM_SRC(N)) dut (
        .clock_16    (clock_16),
        .reset       (reset),
        .irq_src     (irq_src),
        .bus         (bus_if.slave),
        .cpu_irq     (cpu_irq),
        .irq_pending (irq_pending)
    );

    // ---------------- clock ----------------
    always #5 clock_16 = ~clock_16;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_ie, m_if, m_prev;
    logic         m_ime;
    logic         e_cpu, e_pend, e_rvalid, m_rst;
    logic         model_ok = 1'b0;
    logic [15:0]  exp_q[$];
    logic [15:0]  last_rd = 16'h0;

    function automatic logic pending_of(input logic [N-1:0] ie, input logic [N-1:0] fl);
        for (int i = 0; i < N; i++)
            if (ie[i] && fl[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] model_read(input logic [3:0] a);
        logic [15:0] v;
        v = 16'h0;
        for (int i = 0; i < N; i++) begin
            if (a == 4'h0) v[i] = m_ie[i];
            if (a == 4'h2) v[i] = m_if[i];
        end
        if (a == 4'h8) v[0] = m_ime;
        return v;
    endfunction

    function automatic logic [N-1:0] if_after(input logic [N-1:0] fl, input logic [N-1:0] prev,
                                              input logic [N-1:0] src, input logic we,
                                              input logic [3:0] a, input logic [1:0] be,
                                              input logic [15:0] wd);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            if (src[i] && !prev[i])
                r[i] = 1'b1;
            else if (we && a == 4'h2 && be[i / 8] && wd[i])
                r[i] = 1'b0;
            else
                r[i] = fl[i];
        end
        return r;
    endfunction

    function automatic logic [N-1:0] ie_after(input logic [N-1:0] ie, input logic we,
                                              input logic [3:0] a, input logic [1:0] be,
                                              input logic [15:0] wd);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++)
            r[i] = (we && a == 4'h0 && be[i / 8]) ? wd[i] : ie[i];
        return r;
    endfunction

    always @(posedge clock_16) begin
        model_ok <= 1'b1;
        m_rst    <= reset;
        if (reset) begin
            m_ie     <= '0;
            m_if     <= '0;
            m_ime    <= 1'b0;
            m_prev   <= irq_src;
            e_cpu    <= 1'b0;
            e_pend   <= 1'b0;
            e_rvalid <= 1'b0;
            exp_q.delete();
        end else begin
            e_pend   <= pending_of(m_ie, m_if);
            e_cpu    <= m_ime && pending_of(m_ie, m_if);
            e_rvalid <= bus_if.bus_re;
            if (bus_if.bus_re) exp_q.push_back(model_read(bus_if.bus_addr));
            m_prev <= irq_src;
            m_if   <= if_after(m_if, m_prev, irq_src, bus_if.bus_we, bus_if.bus_addr,
                               bus_if.bus_be, bus_if.bus_wdata);
            m_ie   <= ie_after(m_ie, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_be,
                               bus_if.bus_wdata);
            if (bus_if.bus_we && bus_if.bus_addr == 4'h8 && bus_if.bus_be[0])
                m_ime <= bus_if.bus_wdata[0];
        end
    end

    // ---------------- scoreboard compare ----------------
    task automatic compare_outputs();
        if (m_rst) begin
            last_rd = 16'h0;
        end else if (e_rvalid) begin
            if (exp_q.size() == 0) last_rd = 16'hxxxx;
            else                   last_rd = exp_q.pop_front();
        end
        chk("cpu_irq",     {15'b0, cpu_irq},           {15'b0, e_cpu});
        chk("irq_pending", {15'b0, irq_pending},       {15'b0, e_pend});
        chk("bus_rvalid",  {15'b0, bus_if.bus_rvalid}, {15'b0, e_rvalid});
        chk("bus_rdata",   bus_if.bus_rdata,           last_rd);
    endtask

    always @(negedge clock_16) begin
        if (model_ok) compare_outputs();
    end

    // ---------------- driver tasks ----------------
    task automatic bus_cycle(input logic [3:0] a, input logic [15:0] wd, input logic we,
                             input logic [1:0] be, input logic re);
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = wd;
        bus_if.bus_we    = we;
        bus_if.bus_be    = be;
        bus_if.bus_re    = re;
        @(posedge clock_16);
        #1;
        bus_if.bus_we = 1'b0;
        bus_if.bus_re = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_16);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] wd, input logic [1:0] be);
        bus_cycle(a, wd, 1'b1, be, 1'b0);
    endtask

    task automatic rd_lit(input string name, input logic [3:0] a, input logic [15:0] lit);
        bus_cycle(a, 16'h0, 1'b0, 2'b00, 1'b1);
        chk(name, bus_if.bus_rdata, lit);
        chk({name, "_rvalid"}, {15'b0, bus_if.bus_rvalid}, 16'h0001);
    endtask

    task automatic lit_out(input string name, input logic exp_cpu, input logic exp_pend);
        chk({name, "_cpu_irq"},     {15'b0, cpu_irq},     {15'b0, exp_cpu});
        chk({name, "_irq_pending"}, {15'b0, irq_pending}, {15'b0, exp_pend});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  addr_tab [5];
        logic [3:0]  a;
        logic [15:0] wd;
        int          op;

        reset            = 1'b1;
        irq_src          = 14'h0008;
        bus_if.bus_addr  = 4'h0;
        bus_if.bus_wdata = 16'h0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_be    = 2'b00;
        bus_if.bus_re    = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(3);
        lit_out("reset_hold", 1'b0, 1'b0);
        rd_lit("reset_if", 4'h2, 16'h0000);

        // Single-cycle pulse on timer0 with IE bit 3 and IME set.
        irq_src = '0;
        wr(4'h0, 16'h0008, 2'b11);
        wr(4'h8, 16'h0001, 2'b01);
        irq_src = 14'h0008;
        tick(1);
        irq_src = '0;
        lit_out("pulse_n", 1'b0, 1'b0);
        tick(1);
        lit_out("pulse_n1", 1'b1, 1'b1);
        rd_lit("pulse_if", 4'h2, 16'h0008);

        // Write-0 leaves IF alone; write-1 clears and drops the IRQ two edges later.
        wr(4'h2, 16'h0000, 2'b01);
        rd_lit("w0_if", 4'h2, 16'h0008);
        wr(4'h2, 16'h0008, 2'b01);
        lit_out("clr_w", 1'b1, 1'b1);
        tick(1);
        lit_out("clr_w1", 1'b0, 1'b0);
        rd_lit("clr_if", 4'h2, 16'h0000);

        // Clear racing a timer1 rising edge.
        wr(4'h0, 16'h0010, 2'b11);
        irq_src = 14'h0010;
        wr(4'h2, 16'h0010, 2'b01);
        tick(1);
        lit_out("race", 1'b1, 1'b1);
        rd_lit("race_if", 4'h2, 16'h0010);
        irq_src = '0;
        wr(4'h2, 16'h3FFF, 2'b11);
        tick(1);

        // Masked timer2 event, then IE and IME enabling in turn.
        wr(4'h0, 16'h0000, 2'b11);
        irq_src = 14'h0020;
        tick(1);
        irq_src = '0;
        tick(1);
        rd_lit("masked_if", 4'h2, 16'h0020);
        lit_out("masked", 1'b0, 1'b0);
        wr(4'h8, 16'h0000, 2'b01);
        wr(4'h0, 16'h0020, 2'b01);
        tick(1);
        lit_out("ie_on", 1'b0, 1'b1);
        wr(4'h8, 16'h0001, 2'b01);
        lit_out("ime_w", 1'b0, 1'b1);
        tick(1);
        lit_out("ime_w1", 1'b1, 1'b1);

        // Byte enables on IE.
        wr(4'h0, 16'h3FFF, 2'b11);
        wr(4'h0, 16'hFFFF, 2'b10);
        rd_lit("ie_be_hi", 4'h0, 16'h3FFF);
        wr(4'h0, 16'h0000, 2'b01);
        rd_lit("ie_be_lo", 4'h0, 16'h3F00);

        // Unmapped read, rvalid drop and rdata hold.
        rd_lit("unmapped", 4'h4, 16'h0000);
        tick(1);
        chk("rvalid_drop", {15'b0, bus_if.bus_rvalid}, 16'h0000);
        chk("rdata_hold", bus_if.bus_rdata, 16'h0000);

        // Read and write of IME together return the old value.
        bus_cycle(4'h8, 16'h0000, 1'b1, 2'b01, 1'b1);
        chk("ime_rw_old", bus_if.bus_rdata, 16'h0001);
        rd_lit("ime_rw_new", 4'h8, 16'h0000);

        // Randomized traffic.
        addr_tab[0] = 4'h0;
        addr_tab[1] = 4'h2;
        addr_tab[2] = 4'h8;
        addr_tab[3] = 4'h4;
        addr_tab[4] = 4'hF;
        for (int i = 0; i < 3000; i++) begin
            reset   = (i >= 1500 && i < 1502);
            irq_src = irq_src ^ N'($urandom & $urandom & $urandom);
            op      = $urandom_range(0, 3);
            a       = ($urandom_range(0, 7) == 0) ? 4'($urandom) : addr_tab[$urandom_range(0, 4)];
            wd      = 16'($urandom);
            if (a == 4'h2 && $urandom_range(0, 1) == 1) wd = wd & 16'($urandom);
            bus_cycle(a, wd, (op == 1 || op == 3), 2'($urandom), (op == 2 || op == 3));
        end
        reset   = 1'b0;
        irq_src = '0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
